rv32_fetch_ctrl: RTL and testbench

Instruction fetch sequencer that feeds RV32_Decoder. It owns the PC and issues word fetches to instruction memory over a req/ack + rvalid handshake. Returned words are buffered in a small FIFO and presented to the decoder stage with a valid/ready handshake. Execute-stage redirects (branch/jump) flush the FIFO and discard any stale in-flight response.

---
 rtl/rv32_defs.sv | 24 ++
 rtl/rv32_fetch_buf.sv | 59 +++++
 rtl/rv32_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_rv32_fetch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_defs.sv
// Shared fetch-path definitions: widths, FSM encodings, buffer entry layout.
package rv32_defs;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/rv32_fetch_buf.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries; flush wins over push/pop.
module rv32_fetch_buf
  import rv32_defs::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rv32_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one word fetch at a time, buffers returns for decode.
module rv32_fetch_ctrl
  import rv32_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_pc;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_wdata;
  logic             push_c;
  logic             pop_c;
  logic             idle_space_c;
  logic             wait_space_c;

  assign push_c    = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop_c     = instr_valid && instr_ready;
  assign buf_wdata = '{pc: req_pc, instr: imem_rdata};

  // Space with nothing outstanding, and space after the word returning in S_WAIT is pushed.
  assign idle_space_c = !buf_full || pop_c;
  assign wait_space_c = (buf_count + CNT_W'(1) - CNT_W'(pop_c)) < CNT_W'(BUF_DEPTH);

  rv32_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (buf_wdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count),
    .head  (buf_head)
  );

  assign instr_valid = !buf_empty;
  assign instr_data  = buf_head.instr;
  assign instr_pc    = buf_head.pc;
  assign imem_addr   = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      imem_req <= 1'b0;
    end else if (redirect) begin
      // Redirect retargets an unaccepted request; an accepted one must be drained in S_DROP.
      pc <= align_pc(redirect_pc);
      case (state)
        S_WAIT, S_DROP: begin
          state    <= imem_rvalid ? S_REQ : S_DROP;
          imem_req <= imem_rvalid;
        end
        S_REQ: begin
          state    <= imem_ack ? S_DROP : S_REQ;
          imem_req <= !imem_ack;
        end
        default: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (!stall && idle_space_c) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            pc       <= pc + PC_STEP;
            req_pc   <= pc;
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!stall && wait_space_c) begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state    <= stall ? S_IDLE : S_REQ;
            imem_req <= !stall;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// Self-checking bench for rv32_fetch_ctrl: randomized memory responder plus a queue-based reference model.
module tb_rv32_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  // Responder state and knobs
  bit          pend      = 1'b0;
  int          pdly      = 0;
  logic [31:0] paddr     = '0;
  logic [31:0] ack_addr  = '0;
  int          ack_pct   = 100;
  int          dly_min   = 0;
  int          dly_max   = 0;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_word  = '0;
  bit          rand_mode = 1'b0;

  // Reference model state
  ent_t        exp_q[$];
  ent_t        got_q[$];
  logic [31:0] ack_log[$];
  bit          live    = 1'b0;
  logic [31:0] live_pc = '0;
  logic [31:0] exp_pc  = RESET_PC;
  int          sz0;
  logic        p_req   = 1'b0;
  logic        p_ack   = 1'b0;
  logic        p_stall = 1'b0;
  logic        p_redir = 1'b0;
  logic        p_rst   = 1'b1;
  logic [31:0] p_addr  = '0;

  always #5 clk = ~clk;

  rv32_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hdc05_0513;
      32'h0000_0004: return 32'hece7_84e3;
      32'h0000_0008: return 32'h0007_c503;
      default:       return (a * 32'h9e37_79b9) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] got_pc(input int i);
    if (i < got_q.size()) return got_q[i].pc;
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] got_data(input int i);
    if (i < got_q.size()) return got_q[i].instr;
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    if (i < ack_log.size()) return ack_log[i];
    return 32'hdead_beef;
  endfunction

  // One clock: memory responder reacts to the last edge, then drives the next cycle's bus inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (imem_rvalid) pend = 1'b0;
    if (imem_ack) begin
      pend  = 1'b1;
      paddr = ack_addr;
      pdly  = int'($urandom_range(dly_max, dly_min));
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend) begin
      if (pdly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ovr_en ? ovr_word : mem_word(paddr);
        ovr_en      = 1'b0;
      end else begin
        pdly--;
      end
    end
    imem_ack = imem_req && !pend && (int'($urandom_range(99, 0)) < ack_pct);
    ack_addr = imem_addr;
    if (rand_mode) begin
      instr_ready = ($urandom_range(99, 0) < 70);
      stall       = ($urandom_range(99, 0) < 15);
      redirect    = ($urandom_range(99, 0) < 3);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hffff_fff0 | 32'($urandom_range(15, 0)))
                                                : (32'($urandom) & 32'h0000_0fff);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input string name);
    int a = ack_log.size();
    int n = 0;
    while (ack_log.size() == a && n < 30) begin
      step();
      n++;
    end
    check32(name, 32'(ack_log.size() > a), 32'd1);
  endtask

  // Monitor/scoreboard: sees exactly the values the DUT samples at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      live   = 1'b0;
      exp_pc = RESET_PC;
    end else begin
      if (!p_rst) begin
        if (p_req && !p_ack && !p_redir) begin
          check32("req_hold", 32'(imem_req), 32'd1);
          check32("addr_hold", imem_addr, p_addr);
        end
        if (!p_req && imem_req && !p_redir) check32("req_start_under_stall", 32'(p_stall), 32'd0);
      end
      check32("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && exp_q.size() != 0) begin
        check32("instr_pc", instr_pc, exp_q[0].pc);
        check32("instr_data", instr_data, exp_q[0].instr);
      end
      sz0 = exp_q.size();
      if (redirect) begin
        exp_q.delete();
        live   = 1'b0;
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (instr_valid && instr_ready && sz0 != 0) begin
          void'(exp_q.pop_front());
          got_q.push_back(ent_t'{pc: instr_pc, instr: instr_data});
        end
        if (imem_rvalid && live) begin
          exp_q.push_back(ent_t'{pc: live_pc, instr: imem_rdata});
          live = 1'b0;
        end
        if (imem_req && imem_ack) begin
          check32("fetch_addr", imem_addr, exp_pc);
          check32("fetch_space", 32'(sz0 < int'(BUF_DEPTH)), 32'd1);
          ack_log.push_back(imem_addr);
          live    = 1'b1;
          live_pc = exp_pc;
          exp_pc  = exp_pc + 32'd4;
        end
      end
    end
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_stall = stall;
    p_redir = redirect;
    p_rst   = rst;
    p_addr  = imem_addr;
  end

  initial begin
    int a0;
    int g0;
    rst = 1'b1; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    run(2);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_addr", imem_addr, RESET_PC);
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_data", instr_data, 32'd0);
    check32("rst_pc", instr_pc, 32'd0);

    // Sequential fetch with immediate ack and 1-cycle return
    rst = 1'b0; instr_ready = 1'b1;
    run(14);
    check32("seq_addr0", ack_at(0), 32'h0);
    check32("seq_addr1", ack_at(1), 32'h4);
    check32("seq_addr2", ack_at(2), 32'h8);
    check32("seq_pc0", got_pc(0), 32'h0);
    check32("seq_data0", got_data(0), 32'hdc05_0513);
    check32("seq_pc1", got_pc(1), 32'h4);
    check32("seq_data1", got_data(1), 32'hece7_84e3);
    check32("seq_pc2", got_pc(2), 32'h8);
    check32("seq_data2", got_data(2), 32'h0007_c503);

    // Backpressure: buffer fills to two entries, then a single pop admits one more fetch
    stall = 1'b1; run(10);
    instr_ready = 1'b0; stall = 1'b0;
    a0 = ack_log.size(); g0 = got_q.size();
    run(12);
    check32("bp_acks", 32'(ack_log.size() - a0), 32'd2);
    check32("bp_no_pop", 32'(got_q.size() - g0), 32'd0);
    check32("bp_req_low", 32'(imem_req), 32'd0);
    check32("bp_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    run(8);
    check32("bp_pulse_pop", 32'(got_q.size() - g0), 32'd1);
    check32("bp_pulse_acks", 32'(ack_log.size() - a0), 32'd3);
    check32("bp_next_pc", ack_at(a0 + 2), ack_at(a0 + 1) + 32'd4);
    instr_ready = 1'b1; stall = 1'b1; run(10);

    // Redirect while a response is pending
    dly_min = 3; dly_max = 3; stall = 1'b0;
    wait_ack("redir_wait_ack");
    ovr_en = 1'b1; ovr_word = 32'h0081_2c23;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    a0 = ack_log.size(); g0 = got_q.size();
    step();
    redirect = 1'b0; dly_min = 0; dly_max = 0;
    check32("redir_flush", 32'(instr_valid), 32'd0);
    run(12);
    check32("redir_addr", ack_at(a0), 32'h0000_0100);
    check32("redir_first_pc", got_pc(g0), 32'h0000_0100);
    check32("redir_first_data", got_data(g0), mem_word(32'h0000_0100));

    // Alignment and wrap of redirect targets
    a0 = ack_log.size();
    redirect = 1'b1; redirect_pc = 32'h0000_0102; step(); redirect = 1'b0;
    run(6);
    check32("align_addr", ack_at(a0), 32'h0000_0100);
    a0 = ack_log.size();
    redirect = 1'b1; redirect_pc = 32'hffff_fffc; step(); redirect = 1'b0;
    run(8);
    check32("wrap_addr0", ack_at(a0), 32'hffff_fffc);
    check32("wrap_addr1", ack_at(a0 + 1), 32'h0000_0000);

    // Stall does not withdraw an asserted request
    stall = 1'b1; run(10);
    ack_pct = 0; stall = 1'b0;
    g0 = 0;
    while (!imem_req && g0 < 10) begin step(); g0++; end
    check32("stall_req_up", 32'(imem_req), 32'd1);
    stall = 1'b1; run(3);
    check32("stall_req_held", 32'(imem_req), 32'd1);
    a0 = ack_log.size(); ack_pct = 100;
    run(10);
    check32("stall_one_ack", 32'(ack_log.size() - a0), 32'd1);
    check32("stall_req_low", 32'(imem_req), 32'd0);
    stall = 1'b0; run(8);
    check32("stall_resume", 32'(ack_log.size() - a0 >= 2), 32'd1);

    // Reset while waiting; the stray response arrives after reset
    dly_min = 1; dly_max = 1;
    wait_ack("rst_wait_ack");
    ovr_en = 1'b1; ovr_word = 32'h0010_0073;
    rst = 1'b1; step(); rst = 1'b0;
    dly_min = 0; dly_max = 0;
    check32("rst2_req", 32'(imem_req), 32'd0);
    check32("rst2_addr", imem_addr, RESET_PC);
    check32("rst2_valid", 32'(instr_valid), 32'd0);
    check32("rst2_data", instr_data, 32'd0);
    check32("rst2_pc", instr_pc, 32'd0);
    a0 = ack_log.size(); g0 = got_q.size();
    run(10);
    check32("rst2_first_addr", ack_at(a0), RESET_PC);
    check32("rst2_first_pc", got_pc(g0), RESET_PC);
    check32("rst2_first_data", got_data(g0), 32'hdc05_0513);

    // Randomized traffic against the reference model
    g0 = got_q.size();
    ack_pct = 60; dly_min = 0; dly_max = 3; rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0; redirect = 1'b0; stall = 1'b0; instr_ready = 1'b1;
    run(20);
    check32("rand_progress", 32'(got_q.size() - g0 > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
